// File: rtl/fpadder_axi_lite_slave.sv
// AXI4-Lite register front-end for the floating-point adder: OPA/OPB/CTRL-STAT/RESULT
// plus a start/done job handshake. Define FPADDER_IRQ_EN to add the IE bit and irq output.
module fpadder_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
`ifdef FPADDER_IRQ_EN
  output logic                            irq,
`endif
  output logic [C_S_AXI_DATA_WIDTH-1:0]   core_op_a,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   core_op_b,
  output logic                            core_start,
  input  logic                            core_done,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   core_result
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] opa, opb, result, rdata, rd_mux;
  logic          done, ie, start_p, start_go;
  logic          awready, wready, bvalid, arready, rvalid;
  logic          wr_hs, ctrl_wr;
  logic [1:0]    wr_sel;
  logic          unused_ok;

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] cur,
                                                input logic [DW-1:0] nv,
                                                input logic [DW/8-1:0] strb);
    logic [DW-1:0] res;
    res = cur;
    for (int i = 0; i < DW/8; i++)
      if (strb[i]) res[i*8 +: 8] = nv[i*8 +: 8];
    return res;
  endfunction

  assign wr_sel  = S_AXI_AWADDR[3:2];
  assign wr_hs   = awready & S_AXI_AWVALID & wready & S_AXI_WVALID;
  assign ctrl_wr = wr_hs && (wr_sel == 2'd2) && S_AXI_WSTRB[0];
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Job FSM: START is honoured only from IDLE; core_done only from BUSY.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    case (state)
      ST_IDLE: if (ctrl_wr && S_AXI_WDATA[0]) begin
        state_nxt = ST_BUSY;
        start_go  = 1'b1;
      end
      ST_BUSY: if (core_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Write address/data acceptance and response
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      if (!awready && !wready && S_AXI_AWVALID && S_AXI_WVALID && !bvalid) begin
        awready <= 1'b1;
        wready  <= 1'b1;
      end else begin
        awready <= 1'b0;
        wready  <= 1'b0;
      end
      if (wr_hs)             bvalid <= 1'b1;
      else if (S_AXI_BREADY) bvalid <= 1'b0;
    end
  end

  // Register file; a core_done set of DONE outranks a same-edge W1C
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      opa     <= '0;
      opb     <= '0;
      result  <= '0;
      done    <= 1'b0;
      start_p <= 1'b0;
    end else begin
      start_p <= start_go;
      if (wr_hs && wr_sel == 2'd0) opa <= merge_bytes(opa, S_AXI_WDATA, S_AXI_WSTRB);
      if (wr_hs && wr_sel == 2'd1) opb <= merge_bytes(opb, S_AXI_WDATA, S_AXI_WSTRB);
      if (state == ST_BUSY && core_done) begin
        result <= core_result;
        done   <= 1'b1;
      end else if (start_go || (ctrl_wr && S_AXI_WDATA[1])) begin
        done <= 1'b0;
      end
    end
  end

`ifdef FPADDER_IRQ_EN
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (ctrl_wr) ie <= S_AXI_WDATA[3];
      irq <= done & ie;
    end
  end
`else
  assign ie = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (S_AXI_ARADDR[3:2])
      2'd0:    rd_mux = opa;
      2'd1:    rd_mux = opb;
      2'd2:    rd_mux = {{(DW-4){1'b0}}, ie, (state == ST_BUSY), done, 1'b0};
      default: rd_mux = result;
    endcase
  end

  // Read address acceptance and registered read data
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      arready <= !arready && S_AXI_ARVALID && !rvalid;
      if (arready && S_AXI_ARVALID) begin
        rdata  <= rd_mux;
        rvalid <= 1'b1;
      end else if (S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid;
  assign core_op_a     = opa;
  assign core_op_b     = opb;
  assign core_start    = start_p;

endmodule

// File: tb/tb_fpadder_axi_lite_slave.sv
// Bench for fpadder_axi_lite_slave: directed AXI-Lite traffic, a register-level model
// and a per-cycle compare process; irq checks are included when FPADDER_IRQ_EN is set.
module tb_fpadder_axi_lite_slave;

  logic        tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  logic        areset;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] core_op_a, core_op_b, core_result;
  logic        core_start, core_done;
`ifdef FPADDER_IRQ_EN
  logic        irq;
`endif

  fpadder_axi_lite_slave dut (
    .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
`ifdef FPADDER_IRQ_EN
    .irq(irq),
`endif
    .core_op_a(core_op_a), .core_op_b(core_op_b), .core_start(core_start),
    .core_done(core_done), .core_result(core_result)
  );

  // Register-level model, written only by the stimulus process
  logic [31:0] m_opa, m_opb, m_result, m_rd_exp, m_lit;
  bit          m_done, m_busy, m_ie, m_idle_chk;
  int          m_start_cnt, tmo_cnt;
  logic [3:0]  c_addr, c_strb;
  logic [31:0] c_data;

  // Owned by the compare process
  int checks, errors, seen_start, tmo_seen;
  bit irq_prev;

  function automatic void mdl_reset();
    m_opa = 0; m_opb = 0; m_result = 0;
    m_done = 0; m_busy = 0; m_ie = 0;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return m_opa;
      2'd1:    return m_opb;
      2'd2:    return {28'd0, m_ie, m_busy, m_done, 1'b0};
      default: return m_result;
    endcase
  endfunction

  // One clock edge of the register map: bus write effects, then the core's completion
  function automatic void mdl_edge(input bit wr, input logic [3:0] a, input logic [31:0] d,
                                   input logic [3:0] s, input bit dn, input logic [31:0] res);
    bit was_busy;
    was_busy = m_busy;
    if (wr) begin
      case (a[3:2])
        2'd0: for (int i = 0; i < 4; i++) if (s[i]) m_opa[8*i +: 8] = d[8*i +: 8];
        2'd1: for (int i = 0; i < 4; i++) if (s[i]) m_opb[8*i +: 8] = d[8*i +: 8];
        2'd2: if (s[0]) begin
`ifdef FPADDER_IRQ_EN
          m_ie = d[3];
`endif
          if (d[1]) m_done = 0;
          if (d[0] && !was_busy) begin
            m_busy = 1; m_done = 0; m_start_cnt++;
          end
        end
        default: ;
      endcase
    end
    if (dn && was_busy) begin
      m_result = res; m_done = 1; m_busy = 0;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge while out of reset
  initial begin
    bit exp_st;
    checks = 0; errors = 0; seen_start = 0; tmo_seen = 0; irq_prev = 0;
    forever begin
      @(negedge tb_ACLK);
      if (!areset) begin
        chk("core_op_a", core_op_a, m_opa);
        chk("core_op_b", core_op_b, m_opb);
        exp_st = (m_start_cnt > seen_start);
        chk("core_start", 32'(core_start), 32'(exp_st));
        if (exp_st) seen_start++;
        if (bvalid) begin
          chk("bresp", 32'(bresp), 32'd0);
          chk("aw_w_ready_while_bvalid", 32'({awready, wready}), 32'd0);
        end
        if (rvalid) begin
          chk("rresp", 32'(rresp), 32'd0);
          chk("arready_while_rvalid", 32'(arready), 32'd0);
          chk("rdata_model", rdata, m_rd_exp);
          chk("rdata_literal", rdata, m_lit);
        end
        if (m_idle_chk)
          chk("post_reset_idle", 32'({bvalid, rvalid, awready, wready, arready, core_start}), 32'd0);
        if (tmo_cnt != tmo_seen) begin
          chk("handshake_timeout", 32'(tmo_cnt), 32'(tmo_seen));
          tmo_seen = tmo_cnt;
        end
`ifdef FPADDER_IRQ_EN
        chk("irq", 32'(irq), 32'(irq_prev));
`endif
      end
      irq_prev = areset ? 1'b0 : (m_done & m_ie);
    end
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int bhold, input bit wdone, input logic [31:0] res, input bit chain);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    n = 0;
    do begin @(negedge tb_ACLK); n++; end while (!(awready && wready) && n < 50);
    if (n >= 50) begin tmo_cnt++; awvalid = 0; wvalid = 0; return; end
    if (wdone) begin core_done = 1; core_result = res; end
    @(posedge tb_ACLK); #1;
    mdl_edge(1, a, d, s, wdone, res);
    core_done = 0;
    if (chain) begin awaddr = c_addr; wdata = c_data; wstrb = c_strb; end
    else begin awvalid = 0; wvalid = 0; end
    n = 0;
    do begin @(negedge tb_ACLK); n++; end while (!bvalid && n < 50);
    if (n >= 50) begin tmo_cnt++; return; end
    repeat (bhold) @(negedge tb_ACLK);
    bready = 1;
    @(posedge tb_ACLK); #1;
    bready = 0;
  endtask

  task automatic rd(input logic [3:0] a, input int rhold, input bit wdone,
                    input logic [31:0] res, input logic [31:0] lit);
    int n;
    araddr = a; arvalid = 1;
    n = 0;
    do begin @(negedge tb_ACLK); n++; end while (!arready && n < 50);
    if (n >= 50) begin tmo_cnt++; arvalid = 0; return; end
    m_rd_exp = mdl_read(a);
    m_lit = lit;
    if (wdone) begin core_done = 1; core_result = res; end
    @(posedge tb_ACLK); #1;
    arvalid = 0; core_done = 0;
    mdl_edge(0, 4'h0, 32'h0, 4'h0, wdone, res);
    n = 0;
    do begin @(negedge tb_ACLK); n++; end while (!rvalid && n < 50);
    if (n >= 50) begin tmo_cnt++; return; end
    repeat (rhold) @(negedge tb_ACLK);
    rready = 1;
    @(posedge tb_ACLK); #1;
    rready = 0;
  endtask

  task automatic pulse_done(input logic [31:0] res);
    @(negedge tb_ACLK);
    core_done = 1; core_result = res;
    @(posedge tb_ACLK); #1;
    core_done = 0;
    mdl_edge(0, 4'h0, 32'h0, 4'h0, 1, res);
  endtask

  initial begin
    int n;
    areset = 1; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = 0; wstrb = 0; core_done = 0; core_result = 0;
    m_start_cnt = 0; tmo_cnt = 0; m_idle_chk = 0; m_rd_exp = 0; m_lit = 0;
    c_addr = 0; c_data = 0; c_strb = 0;
    mdl_reset();
    repeat (2) @(posedge tb_ACLK);
    #1 areset = 0;
    m_idle_chk = 1;
    @(posedge tb_ACLK); #1 m_idle_chk = 0;
    rd(4'h8, 0, 0, 0, 32'h0);
    rd(4'h0, 0, 0, 0, 32'h0);

    // 1.0 + 2.0 = 3.0
    wr(4'h0, 32'h3F800000, 4'hF, 0, 0, 0, 0);
    wr(4'h4, 32'h40000000, 4'hF, 0, 0, 0, 0);
    wr(4'h8, 32'h00000001, 4'hF, 0, 0, 0, 0);
    repeat (4) @(posedge tb_ACLK);
    pulse_done(32'h40400000);
    rd(4'h8, 0, 0, 0, 32'h2);
    rd(4'hC, 0, 0, 0, 32'h40400000);
    rd(4'h4, 0, 0, 0, 32'h40000000);

    // Byte strobes; RESULT is read-only
    wr(4'h0, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0);
    wr(4'h0, 32'h12345678, 4'h3, 0, 0, 0, 0);
    rd(4'h0, 0, 0, 0, 32'hFFFF5678);
    wr(4'h4, 32'hAABBCCDD, 4'h9, 0, 0, 0, 0);
    rd(4'h4, 0, 0, 0, 32'hAA0000DD);
    wr(4'hC, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
    rd(4'hC, 0, 0, 0, 32'h40400000);

    // Back-pressure on B with a second write already presented, then on R
    c_addr = 4'h4; c_data = 32'hA5A5A5A5; c_strb = 4'hF;
    wr(4'h0, 32'h11111111, 4'hF, 3, 0, 0, 1);
    wr(4'h4, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 0);
    rd(4'h4, 3, 0, 0, 32'hA5A5A5A5);
    rd(4'h0, 2, 0, 0, 32'h11111111);

    // START while BUSY, then W1C colliding with core_done
    wr(4'h8, 32'h1, 4'hF, 0, 0, 0, 0);
    wr(4'h8, 32'h1, 4'hF, 0, 0, 0, 0);
    rd(4'h8, 0, 0, 0, 32'h4);
    wr(4'h0, 32'h01020304, 4'hF, 0, 0, 0, 0);
    wr(4'h8, 32'h2, 4'hF, 0, 1, 32'hC0000000, 0);
    rd(4'h8, 0, 0, 0, 32'h2);
    rd(4'hC, 0, 0, 0, 32'hC0000000);
    // START with strobe 0 is ignored
    wr(4'h8, 32'h1, 4'hE, 0, 0, 0, 0);
    rd(4'h8, 0, 0, 0, 32'h2);

    // STAT read on the core_done edge returns the pre-update value
    wr(4'h8, 32'h1, 4'h1, 0, 0, 0, 0);
    rd(4'h8, 0, 1, 32'h3F000000, 32'h4);
    rd(4'h8, 0, 0, 0, 32'h2);
    rd(4'hC, 0, 0, 0, 32'h3F000000);
    wr(4'h8, 32'h2, 4'h1, 0, 0, 0, 0);
    rd(4'h8, 0, 0, 0, 32'h0);
    pulse_done(32'h12345678);
    rd(4'hC, 0, 0, 0, 32'h3F000000);
    rd(4'h8, 0, 0, 0, 32'h0);

    // Reset in the middle of a read and of a job
    wr(4'h4, 32'h87654321, 4'hF, 0, 0, 0, 0);
    wr(4'h8, 32'h1, 4'hF, 0, 0, 0, 0);
    araddr = 4'h4; arvalid = 1;
    n = 0;
    do begin @(negedge tb_ACLK); n++; end while (!arready && n < 50);
    if (n >= 50) tmo_cnt++;
    m_rd_exp = mdl_read(4'h4);
    m_lit = 32'h87654321;
    @(posedge tb_ACLK); #1 arvalid = 0;
    @(posedge tb_ACLK); #1 areset = 1;
    @(posedge tb_ACLK); #1 areset = 0;
    mdl_reset();
    m_idle_chk = 1;
    @(posedge tb_ACLK); #1 m_idle_chk = 0;
    rd(4'h8, 0, 0, 0, 32'h0);
    rd(4'h0, 0, 0, 0, 32'h0);
    rd(4'h4, 0, 0, 0, 32'h0);
    pulse_done(32'h55555555);
    rd(4'hC, 0, 0, 0, 32'h0);

`ifdef FPADDER_IRQ_EN
    wr(4'h8, 32'h8, 4'h1, 0, 0, 0, 0);
    rd(4'h8, 0, 0, 0, 32'h8);
    wr(4'h8, 32'h9, 4'h1, 0, 0, 0, 0);
    repeat (3) @(posedge tb_ACLK);
    pulse_done(32'h40A00000);
    repeat (3) @(posedge tb_ACLK);
    wr(4'h8, 32'hA, 4'h1, 0, 0, 0, 0);
    rd(4'h8, 0, 0, 0, 32'h8);
`else
    wr(4'h8, 32'h8, 4'hF, 0, 0, 0, 0);
    rd(4'h8, 0, 0, 0, 32'h0);
`endif

    repeat (3) @(posedge tb_ACLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpadder_axi_lite_slave.md
Name: fpadder_axi_lite_slave

Overview:
AXI4-Lite responder (slave) for the floating-point adder IP. It is the bus end addressed by the AXI4-Lite master BFM in the block-design bench. It exposes four 32-bit registers: OPA, OPB, CTRL/STAT and RESULT. It drives the adder core through a start/done handshake and captures the core's result.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, address width; decode uses ADDR[3:2], upper bits ignored (aliasing).

Ports:
S_AXI_ACLK  in  1  single clock, all logic on rising edge
S_AXI_ARESET  in  1  synchronous reset, active-high
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
S_AXI_BRESP  out  2  always 2'b00 (OKAY)
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake
core_op_a  out  32  OPA register contents
core_op_b  out  32  OPB register contents
core_start  out  1  one-cycle start pulse
core_done  in  1  one-cycle completion pulse from the adder
core_result  in  32  valid when core_done=1

Behaviour:
- Reset: every output, register and flag goes to 0. Any in-flight transaction is abandoned: BVALID=0, RVALID=0. Takes effect at the first edge with ARESET=1.
- Register map (offset, name, access):
  - 0x0 OPA, RW.
  - 0x4 OPB, RW.
  - 0x8 CTRL/STAT: bit0 START (write 1 to start, always reads 0); bit1 DONE (sticky, write 1 to clear); bit2 BUSY (read-only); other bits read 0.
  - 0xC RESULT, read-only; writes complete with OKAY and are ignored.
- Write channel:
  - AWREADY and WREADY are registered. Both rise together for exactly one cycle in the cycle after AWVALID=1, WVALID=1, BVALID=0 and both READYs low are sampled.
  - The register update happens on the handshake edge.
  - BVALID rises the next cycle and holds until BVALID&BREADY.
  - No new AW/W is accepted while BVALID=1.
  - AW without W, or W without AW, is not accepted.
- WSTRB:
  - OPA and OPB: byte-wise enables.
  - CTRL: uses WSTRB[0] only.
- Read channel:
  - ARREADY rises for one cycle after ARVALID=1 and RVALID=0 are sampled.
  - On the handshake edge, RDATA is registered from the decoded register and RVALID=1.
  - RDATA and RVALID hold until RREADY. ARREADY stays low while RVALID=1.
- Read and write channels are independent; simultaneous transactions are permitted.
- Core FSM, states IDLE and BUSY:
  - IDLE→BUSY: a CTRL write with START=1 and strobe set. core_start=1 in the cycle after the write handshake edge. BUSY=1 and DONE is cleared at the same time.
  - BUSY→IDLE: on core_done=1, RESULT←core_result, DONE←1, BUSY←0.
  - START while BUSY is ignored: no pulse, no state change.
  - core_done while IDLE is ignored; RESULT is unchanged.
- Collisions:
  - DONE W1C in the same cycle as core_done: the set wins.
  - OPA/OPB writes while BUSY update the registers. The core must latch its operands on core_start.
- Read of STAT in the same cycle as core_done returns the pre-update value.

Optional Feature:
Macro FPADDER_IRQ_EN.
- Defined:
  - Adds an output irq (1 bit), registered, irq = DONE & IE.
  - Adds CTRL bit3 IE (RW, reset 0).
  - irq falls the cycle after DONE is cleared or IE is cleared.
- Undefined: no irq port, and CTRL bit3 reads 0 with writes ignored.

Test Plan:
1. Write OPA=0x3F800000, OPB=0x40000000, CTRL=0x1; the model asserts core_done 5 cycles after core_start with core_result=0x40400000 -> exactly one core_start pulse, read 0x8=0x2, read 0xC=0x40400000, all BRESP/RRESP=OKAY.
2. Write OPA=0xFFFFFFFF (WSTRB=0xF), then OPA=0x12345678 with WSTRB=0x3 -> read 0x0=0xFFFF5678; write 0xC=0xDEADBEEF -> read 0xC unchanged.
3. Hold BREADY=0 for 3 cycles after a write, with a second AW/W pending -> BVALID stays 1, AWREADY/WREADY stay 0 until B completes, then the second write is accepted; same with RREADY low on a read -> RDATA held stable.
4. Write CTRL=0x1 while BUSY -> no second core_start, STAT=0x4; then core_done and a W1C of 0x2 on the same edge -> STAT=0x2.
5. Assert ARESET mid-read (RVALID=1) and mid-job (BUSY=1) -> next cycle RVALID=0, BVALID=0, STAT=0, OPA=OPB=RESULT=0; a later core_done leaves RESULT=0.
6. With FPADDER_IRQ_EN: IE=1, then job completes -> irq=1; write 0x2 to CTRL -> irq=0 next cycle. Without the macro: read 0x8 after writing 0x8 -> 0x0.
